// File: rtl/demux_rr_sched_if.sv
// Stream bundle for demux_rr_sched: producer-side word handshake plus the
// broadcast word, one-hot channel valid, per-channel ready and demux select.
interface demux_rr_sched_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned NCH = 8
);
  localparam int unsigned SW = $clog2(NCH);

  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  out_data;
  logic [NCH-1:0] out_valid;
  logic [NCH-1:0] out_ready;
  logic [SW-1:0]  sel;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel
  );
endinterface

// File: rtl/demux_rr_sched.sv
// Round-robin dispatcher for a 1x8 demux: one-entry holding register steered
// to the next enabled channel. DEMUX_RR_SCHED_CNT_EN adds per-channel delivery counters.
module demux_rr_sched #(
  parameter int unsigned DW  = 8,
  parameter int unsigned NCH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en_mask,
  input  logic                 flush,
  demux_rr_sched_if.slave      bus,
  output logic                 busy
`ifdef DEMUX_RR_SCHED_CNT_EN
  ,
  input  logic [$clog2(NCH)-1:0] cnt_idx,
  output logic [15:0]            cnt_val
`endif
);

  localparam int unsigned SW = $clog2(NCH);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   held_q, held_d;
  logic [SW-1:0]   cur_q, cur_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   ptr_eff;
  logic [SW-1:0]   cand;
  logic            deliver;
  logic            capture;
  logic            in_ready_c;

  assign deliver    = (state_q == FULL) && bus.out_ready[cur_q];
  assign in_ready_c = !rst && !flush && (|en_mask) &&
                      ((state_q == EMPTY) || bus.out_ready[cur_q]);
  assign capture    = bus.in_valid && in_ready_c;
  // A delivery this cycle moves the search start past the channel just served.
  assign ptr_eff    = deliver ? cur_q + SW'(1) : ptr_q;

  // First enabled channel at or after ptr_eff; scanning downward lets the nearest win.
  always_comb begin
    cand = ptr_eff;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (en_mask[ptr_eff + SW'(i)]) cand = ptr_eff + SW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    if (flush) begin
      state_d = EMPTY;
      held_d  = '0;
      cur_d   = '0;
      ptr_d   = '0;
    end else begin
      if (deliver) begin
        ptr_d   = ptr_eff;
        state_d = EMPTY;
      end
      if (capture) begin
        held_d  = bus.in_data;
        cur_d   = cand;
        state_d = FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      held_q  <= '0;
      cur_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = held_q;
  assign bus.out_valid = (state_q == FULL) ? (NCH'(1) << cur_q) : '0;
  assign bus.sel       = cur_q;
  assign busy          = (state_q == FULL);

`ifdef DEMUX_RR_SCHED_CNT_EN
  logic [15:0] cnt_q [NCH];
  logic [15:0] cnt_d [NCH];

  // Counters survive flush: a delivery in the flush cycle still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (deliver) cnt_d[cur_q] = cnt_q[cur_q] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_val = cnt_q[cnt_idx];
`endif

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed bench for demux_rr_sched: a per-cycle reference model plus
// hand-computed delivery sequences for each scenario.
module tb_demux_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] en_mask;
  logic       busy;
`ifdef DEMUX_RR_SCHED_CNT_EN
  logic [2:0]  cnt_idx;
  logic [15:0] cnt_val;
`endif

  int checks   = 0;
  int failures = 0;

  demux_rr_sched_if #(.DW(8), .NCH(8)) bus ();

  demux_rr_sched #(.DW(8), .NCH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en_mask (en_mask),
    .flush   (flush),
    .bus     (bus.slave),
    .busy    (busy)
`ifdef DEMUX_RR_SCHED_CNT_EN
    ,
    .cnt_idx (cnt_idx),
    .cnt_val (cnt_val)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: at most one word in flight.
  bit        m_full;
  int        m_chan;
  int        m_word;
  int        m_ptr;
  int        m_cnt [8];

  // Delivery log, recorded from the DUT for literal comparisons.
  int log_sel [$];
  int log_data[$];
  int log_ov  [$];

  function automatic int next_enabled(input int start, input logic [7:0] mask);
    for (int k = 0; k < 8; k++) begin
      if (mask[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    bit exp_rdy, dlv, cap;
    if (rst) begin
      m_full = 0; m_chan = 0; m_word = 0; m_ptr = 0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end else begin
      exp_rdy = !flush && (en_mask != 8'h00) && (!m_full || bus.out_ready[m_chan]);
      chk("busy", 32'(busy), 32'(m_full));
      chk("out_valid", 32'(bus.out_valid), m_full ? (32'd1 << m_chan) : 32'd0);
      chk("sel", 32'(bus.sel), 32'(m_chan));
      chk("out_data", 32'(bus.out_data), 32'(m_word));
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
`ifdef DEMUX_RR_SCHED_CNT_EN
      chk("cnt_val", 32'(cnt_val), 32'(m_cnt[cnt_idx]));
`endif
      if ((bus.out_valid & bus.out_ready) != 8'h00) begin
        log_sel.push_back(int'(bus.sel));
        log_data.push_back(int'(bus.out_data));
        log_ov.push_back(int'(bus.out_valid));
      end
      dlv = m_full && bus.out_ready[m_chan];
      cap = bus.in_valid && exp_rdy;
      if (dlv) begin
        m_cnt[m_chan] = (m_cnt[m_chan] + 1) % 65536;
        m_ptr = (m_chan + 1) % 8;
      end
      if (flush) begin
        m_full = 0; m_ptr = 0; m_chan = 0; m_word = 0;
      end else if (cap) begin
        m_chan = next_enabled(m_ptr, en_mask);
        m_word = int'(bus.in_data);
        m_full = 1;
      end else if (dlv) begin
        m_full = 0;
      end
    end
  end

  // Entered and left at posedge+1; waits is the number of cycles in_ready was low.
  task automatic send(input logic [7:0] w, output int waits);
    bit done = 0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      else begin
        waits++;
        if (waits > 50) begin
          chk("send_timeout", 32'(waits), 32'd0);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w, base;
    int exp_sel1 [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    int exp_sel2 [4]  = '{1, 5, 1, 5};
    int exp_ov2  [4]  = '{8'h02, 8'h20, 8'h02, 8'h20};
    int n77;

    rst = 1'b1; flush = 1'b0; en_mask = 8'hFF;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 8'hFF;
`ifdef DEMUX_RR_SCHED_CNT_EN
    cnt_idx = 3'd0;
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back stream over all channels, wrapping 7 -> 0.
    base = log_sel.size();
    for (int i = 1; i <= 10; i++) begin
      send(8'(i), w);
      chk("s1_wait", 32'(w), 32'd0);
    end
    idle(2);
    chk("s1_count", 32'(log_sel.size() - base), 32'd10);
    for (int i = 0; i < 10 && base + i < log_sel.size(); i++) begin
      chk("s1_sel", 32'(log_sel[base + i]), 32'(exp_sel1[i]));
      chk("s1_data", 32'(log_data[base + i]), 32'(i + 1));
      chk("s1_ov", 32'(log_ov[base + i]), 32'd1 << exp_sel1[i]);
    end
`ifdef DEMUX_RR_SCHED_CNT_EN
    cnt_idx = 3'd0;
    @(negedge clk);
    chk("cnt0", 32'(cnt_val), 32'd2);
    @(posedge clk); #1;
    cnt_idx = 3'd7;
    @(negedge clk);
    chk("cnt7", 32'(cnt_val), 32'd1);
    @(posedge clk); #1;
`endif

    // Sparse mask: only channels 1 and 5.
    do_flush();
    en_mask = 8'h22;
    base = log_sel.size();
    for (int i = 0; i < 4; i++) send(8'(8'h11 + i), w);
    idle(2);
    chk("s2_count", 32'(log_sel.size() - base), 32'd4);
    for (int i = 0; i < 4 && base + i < log_sel.size(); i++) begin
      chk("s2_sel", 32'(log_sel[base + i]), 32'(exp_sel2[i]));
      chk("s2_ov", 32'(log_ov[base + i]), 32'(exp_ov2[i]));
    end

    // Backpressure on channel 0 holds the word and blocks input.
    en_mask = 8'hFF;
    do_flush();
    bus.out_ready = 8'hFE;
    base = log_sel.size();
    send(8'hAA, w);
    bus.in_valid = 1'b1; bus.in_data = 8'hBB;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s3_hold_ov", 32'(bus.out_valid), 32'h01);
      chk("s3_hold_data", 32'(bus.out_data), 32'hAA);
      chk("s3_hold_rdy", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 8'hFF;
    send(8'hBB, w);
    idle(2);
    chk("s3_count", 32'(log_sel.size() - base), 32'd2);
    if (log_sel.size() >= base + 2) begin
      chk("s3_sel_a", 32'(log_sel[base]), 32'd0);
      chk("s3_data_a", 32'(log_data[base]), 32'hAA);
      chk("s3_sel_b", 32'(log_sel[base + 1]), 32'd1);
      chk("s3_data_b", 32'(log_data[base + 1]), 32'hBB);
    end

    // Mask change while holding for channel 3.
    do_flush();
    bus.out_ready = 8'hF7;
    base = log_sel.size();
    for (int i = 0; i < 4; i++) send(8'(8'h30 + i), w);
    en_mask = 8'h01;
    @(negedge clk);
    chk("s4_hold_ov", 32'(bus.out_valid), 32'h08);
    chk("s4_hold_sel", 32'(bus.sel), 32'd3);
    @(posedge clk); #1;
    bus.out_ready = 8'hFF;
    send(8'h34, w);
    idle(2);
    chk("s4_count", 32'(log_sel.size() - base), 32'd5);
    if (log_sel.size() >= base + 5) begin
      chk("s4_sel_held", 32'(log_sel[base + 3]), 32'd3);
      chk("s4_data_held", 32'(log_data[base + 3]), 32'h33);
      chk("s4_sel_next", 32'(log_sel[base + 4]), 32'd0);
      chk("s4_data_next", 32'(log_data[base + 4]), 32'h34);
    end

    // No channel enabled: nothing is accepted.
    en_mask = 8'h00;
    bus.in_valid = 1'b1; bus.in_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s5_in_ready", 32'(bus.in_ready), 32'd0);
      chk("s5_busy", 32'(busy), 32'd0);
      chk("s5_ov", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;

    // Flush while holding for channel 6.
    en_mask = 8'hFF;
    do_flush();
    bus.out_ready = 8'hBF;
    base = log_sel.size();
    for (int i = 0; i < 7; i++) send(8'(8'h60 + i), w);
    bus.in_valid = 1'b1; bus.in_data = 8'h77; flush = 1'b1;
    @(negedge clk);
    chk("s6_flush_rdy", 32'(bus.in_ready), 32'd0);
    chk("s6_flush_busy", 32'(busy), 32'd1);
    chk("s6_flush_sel", 32'(bus.sel), 32'd6);
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("s6_post_busy", 32'(busy), 32'd0);
    chk("s6_post_ov", 32'(bus.out_valid), 32'd0);
    chk("s6_post_sel", 32'(bus.sel), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 8'hFF;
    send(8'h78, w);
    idle(2);
    chk("s6_count", 32'(log_sel.size() - base), 32'd7);
    if (log_sel.size() >= base + 7) begin
      chk("s6_sel_next", 32'(log_sel[base + 6]), 32'd0);
      chk("s6_data_next", 32'(log_data[base + 6]), 32'h78);
    end
    n77 = 0;
    for (int i = base; i < log_data.size(); i++) if (log_data[i] == 8'h77) n77++;
    chk("s6_no_capture", 32'(n77), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
